// File: rtl/case_2_sdiv_8s_4s_seq_pkg.sv
// Shared definitions for the case_2 sequential signed divider blocks.
//   div_state_e  : divider FSM states
//   DivZeroQuot  : quotient pattern returned on a zero divisor (all ones),
//                  sliced down to the dividend width by each user
package case_2_sdiv_8s_4s_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup,
        StDone
    } div_state_e;

    localparam logic [63:0] DivZeroQuot = '1;

endpackage

// File: rtl/case_2_sdiv_8s_4s_seq.sv
// Sequential signed divider: din0 / din1 with truncation toward zero, using a
// restoring shift-subtract on operand magnitudes, one quotient bit per cycle.
// Ports:
//   ap_clk      : clock, rising edge
//   ap_rst      : synchronous active-high reset
//   ap_start    : begin a division (sampled only while idle)
//   din0, din1  : signed dividend / divisor
//   ap_idle     : high while able to accept ap_start
//   ap_done     : one-cycle pulse, results valid
//   dout_quot   : signed quotient, held until the next ap_done
//   dout_rem    : signed remainder (sign of din0), held until the next ap_done
//   div_by_zero : divisor was zero for the result being reported
module case_2_sdiv_8s_4s_seq
    import case_2_sdiv_8s_4s_seq_pkg::*;
#(
    parameter int unsigned din0_WIDTH = 8,
    parameter int unsigned din1_WIDTH = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [din0_WIDTH-1:0] dout_quot,
    output logic [din1_WIDTH-1:0] dout_rem,
    output logic                  div_by_zero
);

    // One extra bit so the magnitude of the most-negative value is representable.
    localparam int unsigned MagW = din0_WIDTH + 1;
    localparam int unsigned CntW = $clog2(din0_WIDTH + 1);

    div_state_e state_q, state_d;

    logic [CntW-1:0]       cnt_q;
    logic [din0_WIDTH-1:0] quot_q;
    logic [MagW-1:0]       rem_q;
    logic [MagW-1:0]       dsor_q;
    logic                  neg_quot_q;
    logic                  neg_rem_q;
    logic                  dsor_zero_q;

    logic [din0_WIDTH-1:0] dout_quot_q;
    logic [din1_WIDTH-1:0] dout_rem_q;
    logic                  div_by_zero_q;

    // Operand magnitudes
    logic [MagW-1:0] din0_ext, din1_ext, din0_mag, din1_mag;

    always_comb begin
        din0_ext = {din0[din0_WIDTH-1], din0};
        din1_ext = {{(MagW - din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
        din0_mag = din0[din0_WIDTH-1] ? -din0_ext : din0_ext;
        din1_mag = din1[din1_WIDTH-1] ? -din1_ext : din1_ext;
    end

    // Restoring step: shift the next dividend bit into the partial remainder,
    // subtract the divisor if it fits and record the quotient bit.
    logic [MagW-1:0]       rem_shift;
    logic                  step_ge;
    logic [MagW-1:0]       rem_step;
    logic [din0_WIDTH-1:0] quot_step;

    always_comb begin
        rem_shift = {rem_q[din0_WIDTH-1:0], quot_q[din0_WIDTH-1]};
        step_ge   = (rem_shift >= dsor_q);
        rem_step  = step_ge ? (rem_shift - dsor_q) : rem_shift;
        quot_step = {quot_q[din0_WIDTH-2:0], step_ge};
    end

    // Sign fixup. |rem| < |din1| so the remainder always fits din1_WIDTH bits.
    logic [din0_WIDTH-1:0] quot_fix;
    logic [din1_WIDTH-1:0] rem_low, rem_fix;

    always_comb begin
        rem_low = rem_q[din1_WIDTH-1:0];
        if (dsor_zero_q) begin
            quot_fix = DivZeroQuot[din0_WIDTH-1:0];
            rem_fix  = '0;
        end else begin
            quot_fix = neg_quot_q ? -quot_q : quot_q;
            rem_fix  = neg_rem_q ? -rem_low : rem_low;
        end
    end

    // The top magnitude bits are provably zero here; kept for width safety only.
    logic unused_mag_bits;
    assign unused_mag_bits = ^{rem_q[MagW-1], din0_mag[MagW-1]};

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (ap_start) state_d = StCalc;
            StCalc:  if (cnt_q == CntW'(1)) state_d = StFixup;
            StFixup: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt_q         <= '0;
            quot_q        <= '0;
            rem_q         <= '0;
            dsor_q        <= '0;
            neg_quot_q    <= 1'b0;
            neg_rem_q     <= 1'b0;
            dsor_zero_q   <= 1'b0;
            dout_quot_q   <= '0;
            dout_rem_q    <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ap_start) begin
                        cnt_q       <= CntW'(din0_WIDTH);
                        quot_q      <= din0_mag[din0_WIDTH-1:0];
                        rem_q       <= '0;
                        dsor_q      <= din1_mag;
                        neg_quot_q  <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        neg_rem_q   <= din0[din0_WIDTH-1];
                        dsor_zero_q <= (din1 == '0);
                    end
                end
                StCalc: begin
                    cnt_q  <= cnt_q - 1'b1;
                    quot_q <= quot_step;
                    rem_q  <= rem_step;
                end
                StFixup: begin
                    // Result registers load here so they are valid during ap_done.
                    dout_quot_q   <= quot_fix;
                    dout_rem_q    <= rem_fix;
                    div_by_zero_q <= dsor_zero_q;
                end
                default: ;
            endcase
        end
    end

    assign ap_idle     = (state_q == StIdle);
    assign ap_done     = (state_q == StDone);
    assign dout_quot   = dout_quot_q;
    assign dout_rem    = dout_rem_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: doc/case_2_sdiv_8s_4s_seq.md
CASE_2_SDIV_8S_4S_SEQ -- requirements
Module: case_2_sdiv_8s_4s_seq

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 8, dividend width in bits.
REQ-002 SHALL have parameter din1_WIDTH, default 4, divisor width in bits.
REQ-003 SHALL have port ap_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ap_rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 SHALL have port ap_start, input, 1 bit, request to begin a division.
REQ-006 SHALL have port din0, input, din0_WIDTH bits, signed two's-complement dividend.
REQ-007 SHALL have port din1, input, din1_WIDTH bits, signed two's-complement divisor.
REQ-008 SHALL have port ap_idle, output, 1 bit, high when ready to accept ap_start.
REQ-009 SHALL have port ap_done, output, 1 bit, one-cycle pulse when results are valid.
REQ-010 SHALL have port dout_quot, output, din0_WIDTH bits, signed quotient.
REQ-011 SHALL have port dout_rem, output, din1_WIDTH bits, signed remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit, set with ap_done when din1 was zero.

Function
REQ-013 SHALL implement the inverse of the codebase's signed multiply: din0 = dout_quot*din1 + dout_rem, with truncation toward zero.
REQ-014 SHALL give dout_rem the sign of din0 (or zero), with |dout_rem| < |din1|.
REQ-015 SHALL use FSM states IDLE, CALC, FIXUP, DONE.
REQ-016 SHALL, in IDLE with ap_start=1, capture din0/din1, store their magnitudes and signs, and go to CALC.
REQ-017 SHALL, in CALC, perform one restoring shift-subtract step per cycle for exactly din0_WIDTH cycles, counted by a down-counter.
REQ-018 SHALL, in FIXUP, negate the quotient if the operand signs differ and negate the remainder if din0 was negative.
REQ-019 SHALL, in DONE, update dout_quot/dout_rem/div_by_zero, pulse ap_done for one cycle, and return to IDLE.
REQ-020 SHALL assert ap_done exactly din0_WIDTH+2 cycles after the cycle in which ap_start was sampled.
REQ-021 SHALL hold ap_idle high only in IDLE.
REQ-022 SHALL ignore ap_start while not in IDLE; no queuing.
REQ-023 SHALL hold dout_quot, dout_rem and div_by_zero stable from ap_done until the next ap_done.
REQ-024 SHALL, on divisor zero, still take the full latency and output dout_quot=all-ones, dout_rem=0, div_by_zero=1.
REQ-025 SHALL, on the most-negative dividend divided by -1, wrap: dout_quot=most-negative value, dout_rem=0, div_by_zero=0.
REQ-026 SHALL perform internal magnitude arithmetic din0_WIDTH+1 bits wide so that the most-negative operands do not overflow.
REQ-027 SHALL accept ap_start in the cycle immediately after ap_done, giving back-to-back throughput of one result per din0_WIDTH+3 cycles.

Reset
REQ-028 SHALL, with ap_rst=1 at a clock edge, force state IDLE, ap_idle=1, ap_done=0, dout_quot=0, dout_rem=0, div_by_zero=0, counter=0.
REQ-029 SHALL, on reset mid-operation, abort the division with no ap_done pulse.
REQ-030 SHALL give reset priority over ap_start in the same cycle.

Structure
REQ-031 SHALL place the FSM state enumeration and the zero-divisor quotient constant in a shared package for the case_2 divider blocks.
REQ-032 SHALL be a single flat module with no sub-modules; the shift-subtract step is inline logic.

Verification
REQ-033 SHALL test din0=100, din1=7 -> after 10 cycles, ap_done with dout_quot=14, dout_rem=2.
REQ-034 SHALL test din0=-100, din1=7 -> dout_quot=-14, dout_rem=-2; and din0=100, din1=-7 -> dout_quot=-14, dout_rem=2.
REQ-035 SHALL test din0=-128, din1=-1 -> dout_quot=-128, dout_rem=0, div_by_zero=0; and din0=-128, din1=-8 -> dout_quot=16, dout_rem=0.
REQ-036 SHALL test din0=55, din1=0 -> dout_quot=8'hFF, dout_rem=0, div_by_zero=1, with ap_done at the nominal latency.
REQ-037 SHALL test ap_start held high across two ops, with din0 changed during CALC -> the first result uses the captured operands, and the second starts the cycle after ap_done.
REQ-038 SHALL test ap_rst pulsed during CALC -> no ap_done, ap_idle=1 next cycle, and all outputs zero.
